// File: rtl/cpu_pkg.sv
// Shared encodings for the pipelined CPU: load types, write-back sources, link offset.
// Pure definitions, no logic; no latency or backpressure of its own.
// Imported by the MEM/WB stage and its load alignment helper.
package cpu_pkg;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    localparam int LINK_OFS = 8;

    // Bundle presented to the register-file write port and forwarding network.
    typedef struct packed {
        logic        vld;
        logic        we;
        logic [4:0]  rd;
        logic        misalign;
    } wb_ctl_t;

endpackage

// File: rtl/load_align.sv
// Selects and sign/zero-extends the addressed byte/halfword of a little-endian load word.
// Combinational, zero latency.
// No flow control; output follows inputs.
module load_align
    import cpu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] rdata,
    input  logic [2:0]   load_type,
    input  logic [1:0]   a,
    output logic [W-1:0] data,
    output logic         misalign
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b        = rdata[{a, 3'b000} +: 8];
        h        = rdata[{a[1], 4'b0000} +: 16];
        data     = rdata;
        misalign = 1'b0;
        case (load_type)
            LT_LH: begin
                data     = {{(W-16){h[15]}}, h};
                misalign = a[0];
            end
            LT_LHU: begin
                data     = {{(W-16){1'b0}}, h};
                misalign = a[0];
            end
            LT_LB:  data = {{(W-8){b[7]}}, b};
            LT_LBU: data = {{(W-8){1'b0}}, b};
            // Undefined encodings behave as a full-word load.
            default: begin
                data     = rdata;
                misalign = (a != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: load alignment, write-back select, misalign flag, retired counter.
// One falling-edge latency from MEM inputs to WB outputs.
// No handshake: stall holds everything, clear inserts a bubble (clear beats stall).
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [W-1:0]     PC,
    input  logic             regwrite_in,
    input  logic [1:0]       wb_sel,
    input  logic [2:0]       load_type,
    input  logic [4:0]       rd_in,
    input  logic [W-1:0]     alu_in,
    input  logic [W-1:0]     mem_rdata,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [W-1:0]     wb_data,
    output logic [W-1:0]     wb_pc,
    output logic             misalign,
    output logic [CNT_W-1:0] retired_cnt
);

    logic [W-1:0] ld_data;
    logic         ld_mis;
    logic [W-1:0] data_next;
    wb_ctl_t      ctl_next;
    wb_ctl_t      ctl_q;

    load_align #(.W(W)) u_load_align (
        .rdata     (mem_rdata),
        .load_type (load_type),
        .a         (alu_in[1:0]),
        .data      (ld_data),
        .misalign  (ld_mis)
    );

    always_comb begin
        case (wb_sel)
            WB_MEM:  data_next = ld_data;
            WB_LINK: data_next = PC + W'(LINK_OFS);
            default: data_next = alu_in;
        endcase
        ctl_next.vld      = in_valid;
        ctl_next.rd       = rd_in;
        ctl_next.misalign = in_valid && (wb_sel == WB_MEM) && ld_mis;
        // A misaligned load is retired but must not corrupt the register file.
        ctl_next.we       = in_valid && regwrite_in && (rd_in != 5'd0) && !ctl_next.misalign;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q       <= '0;
            wb_data     <= '0;
            wb_pc       <= '0;
            retired_cnt <= '0;
        end else if (clear) begin
            ctl_q   <= '0;
            wb_data <= '0;
            wb_pc   <= '0;
        end else if (!stall) begin
            ctl_q   <= ctl_next;
            wb_data <= data_next;
            wb_pc   <= PC;
            if (in_valid)
                retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    assign wb_valid = ctl_q.vld;
    assign wb_we    = ctl_q.we;
    assign wb_rd    = ctl_q.rd;
    assign misalign = ctl_q.misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        stall;
    logic        in_valid;
    logic [31:0] PC;
    logic        regwrite_in;
    logic [1:0]  wb_sel;
    logic [2:0]  load_type;
    logic [4:0]  rd_in;
    logic [31:0] alu_in;
    logic [31:0] mem_rdata;

    logic        wb_valid, wb_we, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, wb_pc, retired_cnt;

    logic        s_valid, s_we, s_mis;
    logic [4:0]  s_rd;
    logic [31:0] s_data, s_pc;
    logic [3:0]  s_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_cnt = 0;

    mem_wb_stage #(.W(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .stall(stall), .in_valid(in_valid),
        .PC(PC), .regwrite_in(regwrite_in), .wb_sel(wb_sel), .load_type(load_type),
        .rd_in(rd_in), .alu_in(alu_in), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_pc(wb_pc), .misalign(misalign), .retired_cnt(retired_cnt)
    );

    // Narrow-counter instance used only for the wrap check.
    mem_wb_stage #(.W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .stall(stall), .in_valid(in_valid),
        .PC(PC), .regwrite_in(regwrite_in), .wb_sel(wb_sel), .load_type(load_type),
        .rd_in(rd_in), .alu_in(alu_in), .mem_rdata(mem_rdata),
        .wb_valid(s_valid), .wb_we(s_we), .wb_rd(s_rd), .wb_data(s_data),
        .wb_pc(s_pc), .misalign(s_mis), .retired_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic        rw;
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        e_v;
        logic        e_we;
        logic [31:0] e_data;
        logic        e_mis;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                         input logic [2:0] lt, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rdata);
        in_valid = v; regwrite_in = rw; wb_sel = sel; load_type = lt;
        rd_in = rd; PC = pc; alu_in = alu; mem_rdata = rdata;
    endtask

    // Drive just after a rising edge, let the falling edge capture, sample 1 time unit later.
    task automatic capture();
        @(negedge clk);
        #1;
        if (!stall && !clear && in_valid) exp_cnt = exp_cnt + 1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_we"},    {31'd0, wb_we},    32'd0);
        chk({tag, "_rd"},    {27'd0, wb_rd},    32'd0);
        chk({tag, "_data"},  wb_data,           32'd0);
        chk({tag, "_pc"},    wb_pc,             32'd0);
        chk({tag, "_mis"},   {31'd0, misalign}, 32'd0);
    endtask

    initial begin
        //            name        v  rw sel    lt      rd  pc            alu           rdata         e_v e_we e_data        e_mis
        vecs[0]  = '{"lb_a2",    1, 1, 2'b01, 3'b011, 8,  32'h0000_0100, 32'h0000_1002, 32'h80FF_7F01, 1, 1, 32'hFFFF_FFFF, 0};
        vecs[1]  = '{"lbu_a3",   1, 1, 2'b01, 3'b100, 8,  32'h0000_0104, 32'h0000_1003, 32'h80FF_7F01, 1, 1, 32'h0000_0080, 0};
        vecs[2]  = '{"lh_a2",    1, 1, 2'b01, 3'b001, 9,  32'h0000_0108, 32'h0000_1002, 32'h80FF_7F01, 1, 1, 32'hFFFF_80FF, 0};
        vecs[3]  = '{"lh_a1",    1, 1, 2'b01, 3'b001, 9,  32'h0000_010C, 32'h0000_1001, 32'h80FF_7F01, 1, 0, 32'h0000_7F01, 1};
        vecs[4]  = '{"lhu_a2",   1, 1, 2'b01, 3'b010, 10, 32'h0000_0110, 32'h0000_1002, 32'h80FF_7F01, 1, 1, 32'h0000_80FF, 0};
        vecs[5]  = '{"lb_a1",    1, 1, 2'b01, 3'b011, 11, 32'h0000_0114, 32'h0000_1001, 32'h80FF_7F01, 1, 1, 32'h0000_007F, 0};
        vecs[6]  = '{"lw_a0",    1, 1, 2'b01, 3'b000, 12, 32'h0000_0118, 32'h0000_1000, 32'h80FF_7F01, 1, 1, 32'h80FF_7F01, 0};
        vecs[7]  = '{"lw_a2",    1, 1, 2'b01, 3'b000, 12, 32'h0000_011C, 32'h0000_1002, 32'h80FF_7F01, 1, 0, 32'h80FF_7F01, 1};
        vecs[8]  = '{"link",     1, 1, 2'b10, 3'b000, 31, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1, 1, 32'h0000_0004, 0};
        vecs[9]  = '{"alu_rd0",  1, 1, 2'b00, 3'b000, 0,  32'h0000_0120, 32'h0000_ABCD, 32'h0000_0000, 1, 0, 32'h0000_ABCD, 0};
        vecs[10] = '{"sel11",    1, 1, 2'b11, 3'b000, 3,  32'h0000_0124, 32'h0000_DEAD, 32'h1111_1111, 1, 1, 32'h0000_DEAD, 0};
        vecs[11] = '{"invalid",  0, 1, 2'b01, 3'b000, 4,  32'h0000_0128, 32'h0000_1001, 32'h80FF_7F01, 0, 0, 32'h80FF_7F01, 0};
        vecs[12] = '{"lt_bad",   1, 1, 2'b01, 3'b111, 5,  32'h0000_012C, 32'h0000_2000, 32'h1234_5678, 1, 1, 32'h1234_5678, 0};
        vecs[13] = '{"lhu_a1",   1, 0, 2'b01, 3'b010, 6,  32'h0000_0130, 32'h0000_2001, 32'h80FF_7F01, 1, 0, 32'h0000_7F01, 1};

        rst_n = 1'b1; clear = 1'b0; stall = 1'b0;
        drive(0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst0");
        chk("rst0_cnt", retired_cnt, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        exp_cnt = 0;

        // Build the counter to 5, then reset mid-cycle and check without any clock edge.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 2'b00, 3'b000, 7, 32'h40 + i, 32'h99, 0);
            capture();
            @(posedge clk);
        end
        chk("cnt5", retired_cnt, exp_cnt);
        chk("cnt5_abs", retired_cnt, 32'd5);
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1 chk_zero("rstmid");
        chk("rstmid_cnt", retired_cnt, 32'd0);
        exp_cnt = 0;
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].rw, vecs[i].sel, vecs[i].lt, vecs[i].rd,
                  vecs[i].pc, vecs[i].alu, vecs[i].rdata);
            capture();
            chk({vecs[i].name, "_valid"}, {31'd0, wb_valid}, {31'd0, vecs[i].e_v});
            chk({vecs[i].name, "_we"},    {31'd0, wb_we},    {31'd0, vecs[i].e_we});
            chk({vecs[i].name, "_mis"},   {31'd0, misalign}, {31'd0, vecs[i].e_mis});
            chk({vecs[i].name, "_data"},  wb_data,           vecs[i].e_data);
            chk({vecs[i].name, "_rd"},    {27'd0, wb_rd},    {27'd0, vecs[i].rd});
            chk({vecs[i].name, "_pc"},    wb_pc,             vecs[i].pc);
            chk({vecs[i].name, "_cnt"},   retired_cnt,       exp_cnt);
            @(posedge clk);
        end

        // Stall holds everything while inputs change underneath.
        drive(1, 1, 2'b00, 3'b000, 5, 32'h0000_0200, 32'h0000_1234, 0);
        capture();
        chk("st_cap_data", wb_data, 32'h0000_1234);
        @(posedge clk);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2'b00, 3'b000, 6 + i, 32'h300 + i, 32'h5555_0000 + i, 0);
            capture();
            chk("st_hold_data", wb_data, 32'h0000_1234);
            chk("st_hold_rd",   {27'd0, wb_rd}, 32'd5);
            chk("st_hold_pc",   wb_pc, 32'h0000_0200);
            chk("st_hold_cnt",  retired_cnt, exp_cnt);
            @(posedge clk);
        end
        clear = 1'b1;
        capture();
        chk_zero("clr");
        chk("clr_cnt", retired_cnt, exp_cnt);
        @(posedge clk);
        clear = 1'b0; stall = 1'b0;

        // Narrow counter wrap: 15 captures, one more wraps, an invalid one holds.
        @(negedge clk); #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        exp_cnt = 0;
        @(posedge clk);
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 2'b00, 3'b000, 1, 32'h500 + i, i, 0);
            capture();
            @(posedge clk);
        end
        chk("cnt4_15", {28'd0, s_cnt}, 32'd15);
        drive(1, 1, 2'b00, 3'b000, 1, 32'h600, 32'h1, 0);
        capture();
        chk("cnt4_wrap", {28'd0, s_cnt}, 32'd0);
        chk("cnt32_16", retired_cnt, 32'd16);
        @(posedge clk);
        drive(0, 1, 2'b00, 3'b000, 1, 32'h604, 32'h2, 0);
        capture();
        chk("cnt4_inv", {28'd0, s_cnt}, 32'd0);
        chk("cnt32_inv", retired_cnt, exp_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register between the MEM and WB stages of the five-stage pipelined CPU. It captures the MEM-stage result bundle on the falling edge of `clk`. Before capture it aligns and extends load data and selects the write-back value. It flags misaligned loads and keeps a retired-instruction counter. Its registered outputs drive the register-file write port and the forwarding network.

## Interface
Parameters:
- `W`, 32, data/address width.
- `CNT_W`, 32, retired-counter width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the falling edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush; inserts a bubble.
- `stall`  in  1  hold all registers.
- `in_valid`  in  1  MEM stage holds a real instruction.
- `PC`  in  W  PC of the MEM-stage instruction.
- `regwrite_in`  in  1  instruction writes a register.
- `wb_sel`  in  2  write-back source: 00 ALU, 01 load, 10 link (PC+8), 11 reserved (treated as ALU).
- `load_type`  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others treated as LW.
- `rd_in`  in  5  destination register.
- `alu_in`  in  W  ALU result / effective address.
- `mem_rdata`  in  W  data-memory read word, little-endian.
- `wb_valid`  out  1  WB holds a real instruction.
- `wb_we`  out  1  register-file write enable.
- `wb_rd`  out  5  write address.
- `wb_data`  out  W  write data.
- `wb_pc`  out  W  PC of the WB instruction.
- `misalign`  out  1  WB instruction is a misaligned load.
- `retired_cnt`  out  CNT_W  count of valid instructions captured.

## Operation
- Priority: `rst_n`=0, then `clear`, then `stall`, then capture.
- Reset (async): every output goes to 0, including `retired_cnt`.
- `clear`=1 at a falling edge forces a bubble: `wb_valid`, `wb_we`, `misalign`, `wb_rd`, `wb_data` and `wb_pc` all become 0. `retired_cnt` is unchanged. `clear` wins over `stall`.
- `stall`=1 (with `clear`=0): all outputs hold, counter included.
- Capture: `wb_valid`<=`in_valid`, `wb_pc`<=`PC`, `wb_rd`<=`rd_in`.
- Load extraction for `wb_sel`=01, with `a`=`alu_in[1:0]`:
  - LW: the full word.
  - LH/LHU: the halfword at bits `[16*a[1] +: 16]`, sign- or zero-extended.
  - LB/LBU: the byte at bits `[8*a +: 8]`, sign- or zero-extended.
- Write-data select: `wb_sel`=00 or 11 gives `alu_in`; 10 gives `PC+8`, modulo 2^W.
- Misalignment: set when `wb_sel`=01 and `in_valid`=1 and either:
  - LW with `a`!=0, or
  - LH/LHU with `a[0]`=1.
- Misaligned load: `misalign`<=1, `wb_we`<=0, and the data is still captured as extracted.
- Write enable: `wb_we`<=`in_valid` & `regwrite_in` & (`rd_in`!=0) & ~misalign_next.
- Retired counter: increments by 1 at each capture edge with `in_valid`=1, and wraps from all-ones to 0. A misaligned load still counts.

## Timing
- Latency: exactly one falling edge from MEM inputs to WB outputs.
- All outputs are registered and change only on the falling edge or on asynchronous reset assertion.
- Inputs must be stable around the falling edge. The register file writes on the following rising edge.
- Reset may assert mid-stall or mid-flush; its effect is immediate.
- Capture resumes on the first falling edge after `rst_n` rises.
- No handshake: `stall` and `clear` come from the hazard unit and are sampled at the same falling edge as the data.

## Structure
- Shared package `cpu_pkg` holds:
  - the `load_type` encodings (`LT_LW`, `LT_LH`, `LT_LHU`, `LT_LB`, `LT_LBU`);
  - the `wb_sel` encodings (`WB_ALU`, `WB_MEM`, `WB_LINK`);
  - the link offset constant 8.
- One combinational sub-module, `load_align`, takes `mem_rdata`, `load_type` and `a` and produces the extended data and a misalignment flag. The register and counter logic stays in `mem_wb_stage`.

## Test plan
- Reset test: drive `rst_n`=0 mid-cycle with `retired_cnt`=5.
  - All outputs must go to 0 immediately, without waiting for a clock edge.
- LB test: `mem_rdata`=0x80FF7F01, `alu_in`=0x1002, LB, rd=8, regwrite=1.
  - Expected: `wb_data`=0xFFFFFFFF, `wb_we`=1, `wb_rd`=8.
  - Repeat with LBU at `a`=3: expect `wb_data`=0x00000080.
- LH test: `mem_rdata`=0x80FF7F01, LH at `a`=2.
  - Expect `wb_data`=0xFFFF80FF.
  - Repeat at `a`=1: expect `misalign`=1 and `wb_we`=0.
- Link and $zero test: `wb_sel`=10 with `PC`=0xFFFFFFFC.
  - Expect `wb_data`=0x00000004 (wrap).
  - An ALU writeback with rd=0 must give `wb_we`=0 and `wb_valid`=1.
- Stall and clear test: capture `alu_in`=0x1234, then hold `stall` for 3 edges while inputs change.
  - Outputs must hold 0x1234 and the counter must stay constant.
  - Then assert `clear` and `stall` together: expect a bubble with all outputs 0 and the counter unchanged.
- Counter test: preload the counter to all-ones, or use `CNT_W`=4 with 15 valid captures, then capture one more valid instruction.
  - Expect `retired_cnt`=0 (wrap).
  - A capture with `in_valid`=0 must not increment it.
